// File: rtl/alu_serial_ctrl.sv
// ---------------------------------------------------------------------------
// alu_serial_ctrl
//
// Bit-serial controller for an external 1-bit ALU slice. On an accepted start
// the operands and op code are latched, then one bit per clock (LSB first) is
// presented to the slice while its sum bit is shifted back into a result
// shift register. After WIDTH bit-cycles the assembled word, final carry and
// signed overflow are published and done pulses for one cycle.
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst       : asynchronous active-high reset
//   start     : request an operation (accepted in IDLE or DONE, ignored in RUN)
//   op        : 00 NOR, 01 XOR, 10 ADD, 11 SUB
//   a_in/b_in : operands (WIDTH bits)
//   alu_a/alu_b/alu_cin/alu_op : drive into the 1-bit slice (registered)
//   alu_s/alu_cout             : slice sum bit and carry out (combinational)
//   busy      : high exactly while bits are being processed
//   done      : one-cycle completion pulse
//   result    : assembled result word, held until the next operation completes
//   cout/ovf  : final carry / signed overflow, ADD and SUB only
//   zero      : result == 0
// ---------------------------------------------------------------------------
module alu_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cin,
  output logic [1:0]       alu_op,
  input  logic             alu_s,
  input  logic             alu_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] res_sh;   // bits already received, newest at the MSB side
  logic [1:0]       op_reg;
  logic [CW-1:0]    cnt;
  logic             cin_reg;

  // Incoming sum bit joined with the partial result: shifting this right by
  // one each cycle leaves bit i at position i once WIDTH bits have arrived.
  logic [WIDTH-1:0] res_cat;
  assign res_cat = {alu_s, res_sh};

  assign alu_a   = a_sh[0];
  assign alu_b   = b_sh[0];
  assign alu_op  = op_reg;
  assign alu_cin = cin_reg;
  assign zero    = (result == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      op_reg  <= 2'b00;
      cnt     <= '0;
      cin_reg <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh    <= a_in;
            b_sh    <= b_in;
            op_reg  <= op;
            cnt     <= '0;
            // SUB seeds the carry with 1 (two's complement); ADD with 0.
            cin_reg <= op[1] & op[0];
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_cat[WIDTH-1:1];
          if (cnt == LAST) begin
            result  <= res_cat;
            cout    <= op_reg[1] & alu_cout;
            // Carry into the MSB differs from carry out -> signed overflow.
            ovf     <= op_reg[1] & (cin_reg ^ alu_cout);
            cin_reg <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            cnt     <= cnt + 1'b1;
            cin_reg <= op_reg[1] & alu_cout;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
